// File: rtl/decode_pkg.sv
// Shared decode definitions for the ID stage: opcodes, control-field layout and opcode decode.
// Define BNE_EN to decode opcode 0x05 as bne.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam int WB_W     = 2;
  localparam int M_W      = 3;
  localparam int EX_W     = 4;
  localparam int M_BRANCH = 2;

  // rt_used marks opcodes whose rt is a source; invert turns the equality test into inequality.
  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
    logic            rt_used;
    logic            invert;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{wb: 2'b00, m: 3'b000, ex: 4'b0000, rt_used: 1'b0, invert: 1'b0};

  function automatic ctrl_t decode_op(input logic [5:0] op);
    ctrl_t c;
    c = CTRL_NOP;
    case (op)
      OP_RTYPE: c = '{wb: 2'b01, m: 3'b000, ex: 4'b1100, rt_used: 1'b1, invert: 1'b0};
      OP_LW:    c = '{wb: 2'b11, m: 3'b010, ex: 4'b0001, rt_used: 1'b0, invert: 1'b0};
      OP_SW:    c = '{wb: 2'b00, m: 3'b001, ex: 4'b0001, rt_used: 1'b1, invert: 1'b0};
      OP_BEQ:   c = '{wb: 2'b00, m: 3'b100, ex: 4'b0010, rt_used: 1'b1, invert: 1'b0};
      OP_ADDI:  c = '{wb: 2'b01, m: 3'b000, ex: 4'b0001, rt_used: 1'b0, invert: 1'b0};
`ifdef BNE_EN
      OP_BNE:   c = '{wb: 2'b00, m: 3'b100, ex: 4'b0010, rt_used: 1'b1, invert: 1'b1};
`else
      OP_BNE:   c = CTRL_NOP;
`endif
      default:  c = CTRL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_pipe_regfile_p.sv
// Register file: two async read ports, one sync write port, write-through bypass, sync clear.
module regfile_p #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs_r [REG_CNT];

  // Storage update: clear on reset, register 0 never written.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs_r[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Read port A with same-cycle write bypass.
  always_comb begin
    rdata_a = '0;
    if (raddr_a == '0) begin
      rdata_a = '0;
    end else if (we && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end else begin
      rdata_a = regs_r[raddr_a];
    end
  end

  // Read port B with same-cycle write bypass.
  always_comb begin
    rdata_b = '0;
    if (raddr_b == '0) begin
      rdata_b = '0;
    end else if (we && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end else begin
      rdata_b = regs_r[raddr_b];
    end
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// MIPS ID stage: decode, register read, ID-resolved branches, hazard stall and ID/EX register.
// Optional macro BNE_EN (see decode_pkg) enables bne.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int ADDR_W  = 5,
  parameter int PC_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [PC_W-1:0]   if_pc_plus_4,
  input  logic [31:0]       if_inst,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [ADDR_W-1:0] ex_dest,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_ex_valid,
  output logic [WB_W-1:0]   id_ex_wb,
  output logic [M_W-1:0]    id_ex_m,
  output logic [EX_W-1:0]   id_ex_ex,
  output logic [ADDR_W-1:0] id_ex_rs,
  output logic [ADDR_W-1:0] id_ex_rt,
  output logic [ADDR_W-1:0] id_ex_rd,
  output logic [DATA_W-1:0] id_ex_data_a,
  output logic [DATA_W-1:0] id_ex_data_b,
  output logic [DATA_W-1:0] id_ex_imm,
  output logic [PC_W-1:0]   branch_addr,
  output logic              branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush
);

  logic [ADDR_W-1:0] rs_s, rt_s, rd_s;
  logic [15:0]       imm16_s;
  ctrl_t             ctrl_s;
  logic [DATA_W-1:0] rdata_a_s, rdata_b_s, cmp_a_s, cmp_b_s, imm_s;
  logic [PC_W-1:0]   br_off_s;
  logic              is_branch_s, mem_fwd_ok_s, load_use_s, branch_haz_s, stall_s, ops_eq_s;

  assign rs_s    = if_inst[21 +: ADDR_W];
  assign rt_s    = if_inst[16 +: ADDR_W];
  assign rd_s    = if_inst[11 +: ADDR_W];
  assign imm16_s = if_inst[15:0];
  assign ctrl_s  = decode_op(if_inst[31:26]);
  assign imm_s   = {{(DATA_W-16){imm16_s[15]}}, imm16_s};
  assign br_off_s = {{(PC_W-18){imm16_s[15]}}, imm16_s, 2'b00};
  assign is_branch_s = ctrl_s.m[M_BRANCH];

  regfile_p #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .ADDR_W(ADDR_W)) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .we      (wb_reg_write),
    .waddr   (wb_dest),
    .wdata   (wb_data),
    .raddr_a (rs_s),
    .raddr_b (rt_s),
    .rdata_a (rdata_a_s),
    .rdata_b (rdata_b_s)
  );

  // A loaded value in MEM is not ready yet, so only ALU results forward to the comparator.
  assign mem_fwd_ok_s = mem_reg_write && !mem_mem_read && (mem_dest != '0);
  assign cmp_a_s = (mem_fwd_ok_s && (mem_dest == rs_s)) ? mem_alu_result : rdata_a_s;
  assign cmp_b_s = (mem_fwd_ok_s && (mem_dest == rt_s)) ? mem_alu_result : rdata_b_s;
  assign ops_eq_s = (cmp_a_s == cmp_b_s);

  assign load_use_s = ex_mem_read && (ex_dest != '0) &&
                      ((ex_dest == rs_s) || (ctrl_s.rt_used && (ex_dest == rt_s)));
  assign branch_haz_s = is_branch_s &&
      ((ex_reg_write && (ex_dest != '0) && ((ex_dest == rs_s) || (ex_dest == rt_s))) ||
       (mem_mem_read && (mem_dest != '0) && ((mem_dest == rs_s) || (mem_dest == rt_s))));
  assign stall_s = if_valid && (load_use_s || branch_haz_s);

  assign branch_addr  = if_pc_plus_4 + br_off_s;
  assign branch_taken = if_valid && !stall_s && is_branch_s && (ops_eq_s ^ ctrl_s.invert);
  assign ifid_flush   = branch_taken;
  assign pc_write     = !stall_s;
  assign ifid_write   = !stall_s;

  // ID/EX register: reset wins over stall, stall inserts a zeroed bubble.
  always_ff @(posedge clock) begin
    if (reset || stall_s) begin
      id_ex_valid  <= 1'b0;
      id_ex_wb     <= '0;
      id_ex_m      <= '0;
      id_ex_ex     <= '0;
      id_ex_rs     <= '0;
      id_ex_rt     <= '0;
      id_ex_rd     <= '0;
      id_ex_data_a <= '0;
      id_ex_data_b <= '0;
      id_ex_imm    <= '0;
    end else begin
      id_ex_valid  <= if_valid;
      id_ex_wb     <= if_valid ? ctrl_s.wb : '0;
      id_ex_m      <= if_valid ? ctrl_s.m : '0;
      id_ex_ex     <= if_valid ? ctrl_s.ex : '0;
      id_ex_rs     <= rs_s;
      id_ex_rt     <= rt_s;
      id_ex_rd     <= rd_s;
      id_ex_data_a <= rdata_a_s;
      id_ex_data_b <= rdata_b_s;
      id_ex_imm    <= imm_s;
    end
  end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Parametrised instruction-decode stage for the 5-stage MIPS pipeline.
- Decodes IF/ID instruction; reads an internal register file.
- Resolves branches in ID with MEM/WB operand forwarding; detects load-use and branch-operand hazards.
- Drives the registered ID/EX pipeline register, with stall, flush and bubble insertion.

Parameters:
DATA_W, 32, register/data width
REG_CNT, 32, number of architectural registers (power of 2, >=8)
ADDR_W, 5, register index width (= log2 REG_CNT)
PC_W, 32, program-counter width

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  synchronous, active-high reset
if_valid  in  1  IF/ID holds a real instruction
if_pc_plus_4  in  PC_W  PC+4 of the ID instruction
if_inst  in  32  instruction word
ex_reg_write / ex_mem_read  in  1 / 1  control bits of the instruction in EX
ex_dest  in  ADDR_W  EX destination register (after RegDst mux)
mem_reg_write / mem_mem_read  in  1 / 1  control bits of the instruction in MEM
mem_dest  in  ADDR_W  MEM destination register
mem_alu_result  in  DATA_W  MEM-stage ALU result
wb_reg_write  in  1  write-back enable
wb_dest  in  ADDR_W  write-back register
wb_data  in  DATA_W  write-back data
id_ex_valid  out  1  ID/EX holds a real instruction
id_ex_wb / id_ex_m / id_ex_ex  out  2 / 3 / 4  registered control fields
id_ex_rs / id_ex_rt / id_ex_rd  out  ADDR_W each  registered register indices
id_ex_data_a / id_ex_data_b / id_ex_imm  out  DATA_W each  registered operands; sign-extended immediate
branch_addr  out  PC_W  combinational target: if_pc_plus_4 + (sext(imm) << 2), wraps modulo 2^PC_W
branch_taken  out  1  combinational: redirect fetch this cycle
pc_write / ifid_write  out  1 / 1  low = hold PC / hold IF/ID
ifid_flush  out  1  equals branch_taken; squashes the fetched instruction

Behaviour:
- Control encoding:
  - WB = {MemToReg, RegWrite}; M = {Branch, MemRead, MemWrite}; EX = {RegDst, ALUOp[1:0], ALUSrc}.
  - Opcodes: R-type 0x00 -> 01/000/1100; lw 0x23 -> 11/010/0001; sw 0x2B -> 00/001/0001; beq 0x04 -> 00/100/0010; addi 0x08 -> 01/000/0001.
  - Any other opcode -> all-zero control (NOP).
- Register file:
  - REG_CNT x DATA_W; register 0 always reads 0 and ignores writes.
  - Writes occur on the rising edge.
  - Same-cycle write/read of the same non-zero register returns wb_data (write-through bypass).
- Branch compare operands, priority order:
  - MEM forward when mem_reg_write && !mem_mem_read && mem_dest != 0 && mem_dest matches.
  - Otherwise the register-file/bypass value.
- Hazard conditions; any one asserts stall:
  - Load-use: ex_mem_read && ex_dest != 0 && ex_dest in {rs, rt used}.
  - Branch-operand: the ID instruction is a branch and either (ex_reg_write && ex_dest != 0 && ex_dest in {rs, rt}) or (mem_mem_read && mem_dest != 0 && mem_dest in {rs, rt}).
  - rt counts as "used" for R-type, sw and beq only.
  - A load followed by a dependent beq therefore stalls 2 cycles.
- stall = if_valid && hazard:
  - pc_write = ifid_write = 0.
  - ID/EX loads a bubble: valid = 0, all control = 0; data fields are don't-care but held at 0.
- branch_taken = if_valid && !stall && Branch && operands equal.
- Register update with no stall: ID/EX captures the decoded fields; id_ex_valid = if_valid.
  - Control fields are forced to 0 when !if_valid.
- reset: every ID/EX output = 0 on the next edge; register file contents are cleared to 0.
  - Combinational outputs follow inputs; reset does not override them.
- Reset asserted during a stall: reset wins, and ID/EX is zeroed.
- Latency: decode-to-ID/EX is 1 cycle; branch redirect is 0 cycles (combinational into IF).

Optional Feature:
BNE_EN:
- Defined: opcode 0x05 decodes as bne. It has beq's control plus an internal invert flag; branch_taken uses "operands unequal". Hazard rules are the same as beq.
- Undefined: 0x05 is a NOP.

Decomposition:
- Package decode_pkg:
  - Opcode constants.
  - WB/M/EX field widths and bit-index constants.
  - Control-bundle typedef with NOP constant.
- Sub-module regfile_p, parametrised by DATA_W/REG_CNT/ADDR_W: two async read ports, one sync write port, write-through bypass, synchronous reset.

Test Plan:
- R-type add $3,$1,$2 with $1=5, $2=7 -> next cycle id_ex_ex=1100, id_ex_wb=01, data_a=5, data_b=7, id_ex_valid=1.
- lw $4 in EX, then add $5,$4,$1 in ID -> pc_write=0 and ifid_write=0 for 1 cycle; ID/EX bubble (valid=0, control=0); add proceeds the next cycle.
- beq $1,$2 at pc_plus_4=0x100, imm=0x0003, equal regs -> branch_taken=1, branch_addr=0x10C, ifid_flush=1; with imm=0xFFFF -> branch_addr=0xFC.
- beq $6,$1 with lw $6 in EX -> stall 2 cycles; then forwarded/written value compared correctly.
- WB writes $0 with 0xDEAD -> reads 0; WB writes $9=0x1234 while ID reads $9 -> data_a=0x1234 same cycle.
- reset pulse mid-stall -> all id_ex_* = 0 next edge. With BNE_EN, bne on unequal regs -> branch_taken=1.
